// File: rtl/reg_file_8x16.sv
// 8-entry general-purpose register file: two operand read ports, one debug read port,
// and a decoded write port with a registered one-hot trace of the last accepted write.

module decoder3x8 (
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);
  assign onehot_o = 8'h01 << sel_i;
endmodule

module reg_file_8x16 #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [2:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [7:0]       wr_onehot
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [7:0]       wr_onehot_q, wr_onehot_d;
  logic [7:0]       dec;
  logic             wr_accept;
  logic             byp_a, byp_b;

  decoder3x8 u_dec (
    .sel_i    (waddr),
    .onehot_o (dec)
  );

  // A write aimed at a hardwired r0 is dropped entirely, including the trace update.
  assign wr_accept = we && !((ZERO_R0 != 0) && (waddr == 3'd0));

  always_comb begin
    regs_d      = regs_q;
    wr_onehot_d = wr_onehot_q;
    if (wr_accept) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (dec[3'(i)]) regs_d[3'(i)] = wdata;
      end
      wr_onehot_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      wr_onehot_q <= '0;
    end else begin
      regs_q      <= regs_d;
      wr_onehot_q <= wr_onehot_d;
    end
  end

  function automatic logic [WIDTH-1:0] r0_mask(input logic [2:0] addr, input logic [WIDTH-1:0] val);
    return ((ZERO_R0 != 0) && (addr == 3'd0)) ? '0 : val;
  endfunction

  // Bypass only forwards a write that will actually land, so a reset cycle shows stored contents.
  assign byp_a = (BYPASS != 0) && we && !rst && (waddr == raddr_a);
  assign byp_b = (BYPASS != 0) && we && !rst && (waddr == raddr_b);

  assign rdata_a   = r0_mask(raddr_a, byp_a ? wdata : regs_q[raddr_a]);
  assign rdata_b   = r0_mask(raddr_b, byp_b ? wdata : regs_q[raddr_b]);
  assign dbg_data  = r0_mask(dbg_addr, regs_q[dbg_addr]);
  assign wr_onehot = wr_onehot_q;

endmodule
